// File: rtl/bcd2binary_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// Ports: start/bcd_in (master->slave), busy/done/err/bin_out (slave->master).
interface bcd2binary_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    modport master (
        output start, bcd_in,
        input  busy, done, err, bin_out
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, err, bin_out
    );
endinterface

// File: rtl/bcd2binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Ports: clk, rst (sync, active-high), bus (slave: start/bcd_in in; busy/done/err/bin_out out).
module bcd2binary_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    bcd2binary_seq_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q;
    logic [W-1:0]      bcd_q;
    logic [W-1:0]      acc_q;
    logic [CW-1:0]     cnt_q;
    logic [BIN_W-1:0]  bin_q;
    logic              err_q;
    logic              busy_q;
    logic              done_q;

    logic              in_bad;
    logic [2*W-1:0]    sh;
    logic [W-1:0]      bcd_d;
    logic [W-1:0]      acc_d;
    logic              last;

    // Any captured digit above 9 makes the whole request invalid.
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    // One right shift of {bcd, acc}, then fix up every BCD digit that
    // landed at 8 or above; such a digit cannot underflow on -3.
    always_comb begin
        sh    = {bcd_q, acc_q} >> 1;
        acc_d = sh[W-1:0];
        bcd_d = sh[2*W-1:W];
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_d[4*i +: 4] >= 4'd8) begin
                bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
            end
        end
    end

    assign last = (cnt_q == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (in_bad) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            bin_q   <= '0;
                        end else begin
                            bcd_q   <= bus.bcd_in;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        bin_q   <= BIN_W'(acc_d);
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.bin_out = bin_q;
endmodule

// File: tb/tb_bcd2binary_seq.sv
// Scoreboard bench for bcd2binary_seq: random and directed conversions
// compared against a decimal-arithmetic reference model.
module tb_bcd2binary_seq;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int LAT    = 4 * DIGITS + 1;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    bcd2binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bif ();

    bcd2binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Decimal value of the digits; any non-decimal digit is an error.
    function automatic void model(input logic [11:0] b, output logic e,
                                  output int v);
        int p;
        int d;
        v = 0;
        e = 1'b0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((b >> (4 * i)) & 12'hF);
            if (d > 9) e = 1'b1;
            v += d * p;
            p *= 10;
        end
        if (e) v = 0;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'(v / 100);
        return r;
    endfunction

    // Called at posedge+1 of cycle c; returns at posedge+1 of cycle c+1.
    task automatic issue(input logic [11:0] b, output int lat);
        logic e;
        int   v;
        exp_t x;
        model(b, e, v);
        lat   = e ? 1 : LAT;
        x.bin = BIN_W'(v);
        x.err = e;
        x.cyc = cyc + lat;
        sb.push_back(x);
        bif.start  = 1'b1;
        bif.bcd_in = b;
        @(posedge clk); #1;
        bif.start  = 1'b0;
        bif.bcd_in = 12'($urandom);
    endtask

    // Leaves the bench in the done cycle so the next call is back-to-back.
    task automatic run(input logic [11:0] b);
        int lat;
        issue(b, lat);
        repeat (lat - 1) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t x;
        if (!rst && bif.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 at cycle %0d required no pending result",
                         cyc);
            end else begin
                x = sb.pop_front();
                chk("bin_out", 32'(bif.bin_out), 32'(x.bin));
                chk("err", 32'(bif.err), 32'(x.err));
                chk("done_cycle", cyc, x.cyc);
                chk("busy_at_done", 32'(bif.busy), 0);
            end
        end
    end

    initial begin
        int lat;
        bif.start  = 1'b0;
        bif.bcd_in = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bif.busy), 0);
        chk("rst_done", 32'(bif.done), 0);
        chk("rst_err", 32'(bif.err), 0);
        chk("rst_bin", 32'(bif.bin_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero input with explicit busy window.
        issue(12'h000, lat);
        for (int k = 1; k <= 4 * DIGITS; k++) begin
            @(negedge clk);
            chk("busy_window", 32'(bif.busy), 1);
            chk("no_early_done", 32'(bif.done), 0);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;

        run(12'h255);
        run(12'h999);

        // Exhaustive back-to-back sweep.
        for (int v = 0; v < 1000; v++) begin
            run(to_bcd(v));
        end

        // Random patterns, including non-decimal digits.
        repeat (60) run(12'($urandom));
        @(posedge clk); #1;

        // Error then a valid start in the error's done cycle.
        run(12'h1A5);
        issue(12'h042, lat);
        @(negedge clk);
        chk("err_cleared", 32'(bif.err), 0);
        chk("bin_held_after_err", 32'(bif.bin_out), 0);
        repeat (lat - 1) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;

        // Start pulsed while busy and bcd_in scrambled mid-conversion.
        issue(12'h123, lat);
        repeat (4) begin
            @(posedge clk); #1;
        end
        bif.start  = 1'b1;
        bif.bcd_in = 12'h999;
        @(posedge clk); #1;
        bif.start  = 1'b0;
        repeat (10) begin
            bif.bcd_in = 12'($urandom);
            @(posedge clk); #1;
        end

        // Reset in the middle of a conversion.
        issue(12'h500, lat);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(bif.busy), 0);
        chk("midrst_done", 32'(bif.done), 0);
        chk("midrst_bin", 32'(bif.bin_out), 0);
        repeat (20) begin
            @(posedge clk); #1;
        end

        run(12'h007);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("bin_hold", 32'(bif.bin_out), 7);
        chk("err_hold", 32'(bif.err), 0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missed_done: got %0d pending results required 0",
                     sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd2binary_seq.md
Name: bcd2binary_seq

Overview:
- Sequential packed-BCD to binary converter, the inverse of the team's combinational binary-to-BCD block.
- Converts DIGITS BCD digits to an unsigned binary value using reverse double-dabble: one shift per clock, start/done handshake.
- Sits between keypad/display-entry logic and arithmetic datapaths.
- Rejects non-decimal digits with an error flag.

Parameters:
- DIGITS, 3, number of BCD digits in bcd_in; legal values are 1 to 8.
- BIN_W, 10, width of bin_out; must be >= ceil(log2(10^DIGITS)), which is 10 for DIGITS=3.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only when busy=0.
- bcd_in  input  4*DIGITS  packed BCD; [3:0] is units, [7:4] is tens, and so on. Captured in the start cycle.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the result (or error) is valid.
- err  output  1  high with done if any captured digit was >9; held until the next accepted start.
- bin_out  output  BIN_W  binary result; held until the next accepted start.

Behaviour:
- Reset: on any clk edge with rst=1, the block goes to IDLE.
  - Outputs: busy=0, done=0, err=0, bin_out=0.
  - Internal shift register and counter are cleared.
  - Reset mid-conversion abandons the conversion; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1, all digits valid:
  - Load the BCD shift register from bcd_in and clear the binary accumulator (width 4*DIGITS).
  - Set the counter to 0 and go to SHIFT.
- IDLE, start=1, any digit >9: go to DONE with err=1 and bin_out=0.
- SHIFT, each cycle:
  - Shift the concatenation {bcd_reg, acc} right by 1.
  - Then, in every BCD digit of the result, any digit >=8 has 3 subtracted.
  - Increment the counter.
  - After the 4*DIGITS-th shift, load bin_out with acc[BIN_W-1:0], set err=0 and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0.
  - start=1 in DONE is accepted exactly as in IDLE, so back-to-back conversions are allowed.
  - Otherwise go to IDLE.
- busy=1 only in SHIFT.
- start while busy=1 is ignored, and bcd_in changes during SHIFT have no effect.
- Latency: with start presented in cycle 0, busy=1 in cycles 1 to 4*DIGITS and done=1 in cycle 4*DIGITS+1. For DIGITS=3 that is cycle 13.
- Error latency: done=1 and err=1 in cycle 1.
- bin_out and err are stable from done until the cycle after the next accepted start.
  - On that start, err clears.
  - bin_out holds its old value until overwritten at completion.
- The subtract-3 correction is combinational on the shifted value, within the same cycle. No digit underflows because a corrected digit is always >=8.
- The maximum input 10^DIGITS-1 must fit in BIN_W. This is a configuration constraint, not checked at runtime.

Test Plan:
- Reset, then bcd_in=12'h000 with start for 1 cycle:
  - busy high for cycles 1 to 12.
  - done pulse at cycle 13 with bin_out=0, err=0.
- bcd_in=12'h255: bin_out=255 (10'h0FF) at done. Then 12'h999: bin_out=999 (10'h3E7).
- Exhaustive sweep 0 to 999 with back-to-back starts issued in the DONE cycle:
  - every result matches the reference value.
  - done occurs every 13 cycles.
  - no done is missed.
- bcd_in=12'h1A5:
  - done and err both high in cycle 1, bin_out=0.
  - A following valid start of 12'h042 clears err and yields bin_out=42.
- Start 12'h123, pulse start again at cycle 5 with bcd_in=12'h999, and change bcd_in mid-conversion:
  - the cycle-5 start is ignored.
  - result is 123 at cycle 13.
- Start 12'h500 and assert rst at cycle 6:
  - next cycle busy=0, done=0, bin_out=0.
  - no done pulse follows.
  - a fresh start of 12'h007 yields bin_out=7.
